// File: rtl/local_bus_arbiter.sv
`timescale 1ns/1ps
// Arbiter for the 68040 local bus, shared between the CPU and the PCI bridge DMA master.
// The CPU is parked on the bus by default. DMA tenure is bounded, and a locked CPU sequence is never broken.
module local_bus_arbiter #(
    parameter int DMA_MAX_CLKS  = 64,
    parameter int GRANT_TIMEOUT = 8
) (
    input  logic       CLK40,
    input  logic       RESETn,
    input  logic       BR_CPUn,
    input  logic       LOCK_CPUn,
    input  logic       BB_CPUn,
    input  logic       BR_DMAn,
    input  logic       BB_DMAn,
    output logic       BG_CPUn,
    output logic       BG_DMAn,
    output logic       DMA_ACTIVE,
    output logic [2:0] ARB_STATE
);

    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_CPU_GRANT = 3'd1,
        ST_CPU_REL   = 3'd2,
        ST_DMA_GNT   = 3'd3,
        ST_DMA_OWN   = 3'd4,
        ST_DMA_REL   = 3'd5
    } arb_state_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_e;

    localparam logic [7:0] TCNT_LAST = 8'(DMA_MAX_CLKS - 1);
    localparam logic [7:0] TCNT_SAT  = 8'(DMA_MAX_CLKS);
    localparam logic [3:0] GCNT_LAST = 4'(GRANT_TIMEOUT - 1);

    arb_state_e state;
    arb_state_e state_nxt;
    owner_e     last_owner;
    logic [7:0] tcnt;
    logic [3:0] gcnt;
    // Set once the relevant BB line has been seen high on the previous edge in this state.
    logic       idle_seen;

    assign ARB_STATE = state;

    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_RST: state_nxt = ST_CPU_GRANT;
            ST_CPU_GRANT: begin
                if (!BR_DMAn && LOCK_CPUn && (BR_CPUn || last_owner == OWNER_CPU))
                    state_nxt = ST_CPU_REL;
            end
            ST_CPU_REL: begin
                if (BR_DMAn)
                    state_nxt = ST_CPU_GRANT;
                else if (BB_CPUn && idle_seen)
                    state_nxt = ST_DMA_GNT;
            end
            ST_DMA_GNT: begin
                if (!BB_DMAn)
                    state_nxt = ST_DMA_OWN;
                else if (gcnt == GCNT_LAST || BR_DMAn)
                    state_nxt = ST_DMA_REL;
            end
            ST_DMA_OWN: begin
                if ((!BR_CPUn && tcnt == TCNT_LAST) || BR_DMAn || (BB_DMAn && idle_seen))
                    state_nxt = ST_DMA_REL;
            end
            ST_DMA_REL: begin
                // A master still holding BB is never forced off the bus.
                if (BB_DMAn && idle_seen)
                    state_nxt = ST_CPU_GRANT;
            end
            default: state_nxt = ST_RST;
        endcase
    end

    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state      <= ST_RST;
            last_owner <= OWNER_CPU;
            tcnt       <= '0;
            gcnt       <= '0;
            idle_seen  <= 1'b0;
            BG_CPUn    <= 1'b1;
            BG_DMAn    <= 1'b1;
            DMA_ACTIVE <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every term below sees pre-edge state.
            state <= state_nxt;

            // Outputs decode the next state, so they are registered and change with the state.
            BG_CPUn    <= (state_nxt != ST_CPU_GRANT);
            BG_DMAn    <= !(state_nxt inside {ST_DMA_GNT, ST_DMA_OWN});
            DMA_ACTIVE <= state_nxt inside {ST_DMA_GNT, ST_DMA_OWN, ST_DMA_REL};

            if (state_nxt != state) begin
                idle_seen <= 1'b0;
            end else begin
                case (state)
                    ST_CPU_REL:             idle_seen <= BB_CPUn;
                    ST_DMA_OWN, ST_DMA_REL: idle_seen <= BB_DMAn;
                    default:                idle_seen <= 1'b0;
                endcase
            end

            if (state != ST_DMA_GNT)
                gcnt <= '0;
            else if (gcnt != GCNT_LAST)
                gcnt <= gcnt + 4'd1;

            if (state != ST_DMA_OWN)
                tcnt <= '0;
            else if (!BR_CPUn && tcnt != TCNT_SAT)
                tcnt <= tcnt + 8'd1;

            if (state == ST_DMA_GNT && state_nxt == ST_DMA_OWN)
                last_owner <= OWNER_DMA;
            else if (state == ST_DMA_REL && state_nxt == ST_CPU_GRANT)
                last_owner <= OWNER_CPU;
        end
    end

endmodule
